// File: rtl/id_stage_if.sv
// Bundle of the IF/ID, write-back, flush/stall and ID/EX signals around the decode stage.
// The slave modport is the decode stage; the master modport is the surrounding pipeline.
interface id_stage_if #(parameter int XLEN = 32);
   logic            IFID_valid;
   logic [XLEN-1:0] IFID_d_pc;
   logic [31:0]     IFID_d_inst;
   logic            WB_c_EnWReg;
   logic [4:0]      WB_d_ixrd;
   logic [XLEN-1:0] WB_d_rd;
   logic            EX_c_flush;
   logic            ID_c_stall;
   logic            IDEX_valid;
   logic [XLEN-1:0] IDEX_d_pc;
   logic [31:0]     IDEX_d_inst;
   logic [XLEN-1:0] IDEX_d_rs1;
   logic [XLEN-1:0] IDEX_d_rs2;
   logic [XLEN-1:0] IDEX_d_imm;

   modport master (
      output IFID_valid, IFID_d_pc, IFID_d_inst,
      output WB_c_EnWReg, WB_d_ixrd, WB_d_rd, EX_c_flush,
      input  ID_c_stall, IDEX_valid, IDEX_d_pc, IDEX_d_inst,
      input  IDEX_d_rs1, IDEX_d_rs2, IDEX_d_imm
   );

   modport slave (
      input  IFID_valid, IFID_d_pc, IFID_d_inst,
      input  WB_c_EnWReg, WB_d_ixrd, WB_d_rd, EX_c_flush,
      output ID_c_stall, IDEX_valid, IDEX_d_pc, IDEX_d_inst,
      output IDEX_d_rs1, IDEX_d_rs2, IDEX_d_imm
   );
endinterface

// File: rtl/id_stage.sv
// RV32I/RV64I decode stage: register file, immediate generator, load-use stall,
// branch flush and the ID/EX pipeline register.
module id_stage #(
   parameter int XLEN   = 32,
   parameter bit BYPASS = 1'b1
) (
   input logic    clk,
   input logic    rst,
   id_stage_if.slave bus
);
   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
   localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
   localparam logic [6:0]  OPC_JALR  = 7'b1100111;
   localparam logic [6:0]  OPC_STORE = 7'b0100011;
   localparam logic [6:0]  OPC_BR    = 7'b1100011;
   localparam logic [6:0]  OPC_LUI   = 7'b0110111;
   localparam logic [6:0]  OPC_AUIPC = 7'b0010111;
   localparam logic [6:0]  OPC_JAL   = 7'b1101111;
   localparam logic [6:0]  OPC_OP    = 7'b0110011;

   logic [XLEN-1:0] regs [32];
   logic [31:0]     inst;
   logic [4:0]      ix1, ix2, idex_rd;
   logic [6:0]      opc;
   logic            wb_we, use1, use2, hazard, stall;
   logic [XLEN-1:0] rs1_val, rs2_val, imm;
   logic [31:0]     imm32;

   assign inst    = bus.IFID_d_inst;
   assign ix1     = inst[19:15];
   assign ix2     = inst[24:20];
   assign opc     = inst[6:0];
   assign wb_we   = bus.WB_c_EnWReg && (bus.WB_d_ixrd != 5'd0);
   assign idex_rd = bus.IDEX_d_inst[11:7];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_we) begin
         regs[bus.WB_d_ixrd] <= bus.WB_d_rd;
      end
   end

   // x0 is forced to zero on read; the bypass only fires for nonzero indices via wb_we
   always_comb begin
      rs1_val = regs[ix1];
      if (ix1 == 5'd0)                             rs1_val = '0;
      else if (BYPASS && wb_we && bus.WB_d_ixrd == ix1) rs1_val = bus.WB_d_rd;
   end

   always_comb begin
      rs2_val = regs[ix2];
      if (ix2 == 5'd0)                             rs2_val = '0;
      else if (BYPASS && wb_we && bus.WB_d_ixrd == ix2) rs2_val = bus.WB_d_rd;
   end

   always_comb begin
      imm32 = '0;
      case (opc)
         OPC_OPIMM, OPC_LOAD, OPC_JALR: imm32 = {{20{inst[31]}}, inst[31:20]};
         OPC_STORE: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         OPC_BR:    imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC: imm32 = {inst[31:12], 12'b0};
         OPC_JAL:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default:   imm32 = '0;
      endcase
      imm = XLEN'(signed'(imm32));
   end

   assign use1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
   assign use2 = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BR);

   assign hazard = bus.IDEX_valid && (bus.IDEX_d_inst[6:0] == OPC_LOAD) &&
                   (idex_rd != 5'd0) && bus.IFID_valid &&
                   ((use1 && ix1 == idex_rd) || (use2 && ix2 == idex_rd));
   assign stall  = hazard && !bus.EX_c_flush;
   assign bus.ID_c_stall = stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst || bus.EX_c_flush || stall) begin
         bus.IDEX_valid  <= 1'b0;
         bus.IDEX_d_pc   <= '0;
         bus.IDEX_d_inst <= NOP;
         bus.IDEX_d_rs1  <= '0;
         bus.IDEX_d_rs2  <= '0;
         bus.IDEX_d_imm  <= '0;
      end else begin
         bus.IDEX_valid  <= bus.IFID_valid;
         bus.IDEX_d_pc   <= bus.IFID_d_pc;
         bus.IDEX_d_inst <= inst;
         bus.IDEX_d_rs1  <= rs1_val;
         bus.IDEX_d_rs2  <= rs2_val;
         bus.IDEX_d_imm  <= imm;
      end
   end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a 32-bit bypassing instance and a 64-bit non-bypassing
// instance see identical stimulus and are checked against hand-computed values.
module tb_id_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid;
   logic [63:0] pc;
   logic [31:0] inst;
   logic        wb_en;
   logic [4:0]  wb_ix;
   logic [63:0] wb_rd;
   logic        flush;
   int          total = 0;
   int          bad   = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   always #5 clk = ~clk;

   id_stage_if #(.XLEN(32)) ia ();
   id_stage_if #(.XLEN(64)) ib ();

   assign ia.IFID_valid  = valid;
   assign ia.IFID_d_pc   = pc[31:0];
   assign ia.IFID_d_inst = inst;
   assign ia.WB_c_EnWReg = wb_en;
   assign ia.WB_d_ixrd   = wb_ix;
   assign ia.WB_d_rd     = wb_rd[31:0];
   assign ia.EX_c_flush  = flush;
   assign ib.IFID_valid  = valid;
   assign ib.IFID_d_pc   = pc;
   assign ib.IFID_d_inst = inst;
   assign ib.WB_c_EnWReg = wb_en;
   assign ib.WB_d_ixrd   = wb_ix;
   assign ib.WB_d_rd     = wb_rd;
   assign ib.EX_c_flush  = flush;

   id_stage #(.XLEN(32), .BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   id_stage #(.XLEN(64), .BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] i, input logic [63:0] p);
      valid = 1'b1;
      inst  = i;
      pc    = p;
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, "_a_valid"}, 64'(ia.IDEX_valid), 64'd0);
      chk({tag, "_a_inst"},  64'(ia.IDEX_d_inst), 64'(NOP));
      chk({tag, "_a_pc"},    64'(ia.IDEX_d_pc), 64'd0);
      chk({tag, "_b_valid"}, 64'(ib.IDEX_valid), 64'd0);
      chk({tag, "_b_inst"},  64'(ib.IDEX_d_inst), 64'(NOP));
      chk({tag, "_b_pc"},    ib.IDEX_d_pc, 64'd0);
   endtask

   logic [31:0] imm_inst [6];
   logic [63:0] imm_ea   [6];
   logic [63:0] imm_eb   [6];

   initial begin
      valid = 1'b0; pc = '0; inst = NOP;
      wb_en = 1'b0; wb_ix = '0; wb_rd = '0; flush = 1'b0;

      // reset: asynchronous, visible before any clock edge
      #1 rst = 1'b1;
      #2;
      chk_bubble("rst");
      chk("rst_a_rs1",   64'(ia.IDEX_d_rs1), 64'd0);
      chk("rst_a_rs2",   64'(ia.IDEX_d_rs2), 64'd0);
      chk("rst_a_imm",   64'(ia.IDEX_d_imm), 64'd0);
      chk("rst_b_imm",   ib.IDEX_d_imm, 64'd0);
      chk("rst_a_stall", 64'(ia.ID_c_stall), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 32; i++) begin
         issue({12'h000, 5'(i), 3'b000, 5'd1, 7'h13}, 64'd0);
         tick();
         chk($sformatf("rf_zero_x%0d", i), 64'(ia.IDEX_d_rs1), 64'd0);
      end

      // write x5, then read it back with addi x6,x5,0
      valid = 1'b0; wb_en = 1'b1; wb_ix = 5'd5; wb_rd = 64'hDEAD_BEEF;
      tick();
      wb_en = 1'b0;
      issue(32'h0002_8313, 64'h100);
      tick();
      chk("wbrd_a_rs1",   64'(ia.IDEX_d_rs1), 64'hDEAD_BEEF);
      chk("wbrd_a_imm",   64'(ia.IDEX_d_imm), 64'd0);
      chk("wbrd_a_valid", 64'(ia.IDEX_valid), 64'd1);
      chk("wbrd_a_pc",    64'(ia.IDEX_d_pc), 64'h100);
      chk("wbrd_b_rs1",   ib.IDEX_d_rs1, 64'hDEAD_BEEF);

      // same-cycle write and read of x7
      wb_en = 1'b1; wb_ix = 5'd7; wb_rd = 64'h1234;
      issue(32'h0003_8413, 64'h104);
      tick();
      chk("byp_a_rs1", 64'(ia.IDEX_d_rs1), 64'h1234);
      chk("byp_b_rs1", ib.IDEX_d_rs1, 64'd0);
      wb_en = 1'b0;
      tick();
      chk("byp_b_later_rs1", ib.IDEX_d_rs1, 64'h1234);

      // write to x0 while reading x0
      wb_en = 1'b1; wb_ix = 5'd0; wb_rd = 64'hFFFF;
      issue(32'h0000_0093, 64'h108);
      tick();
      chk("x0w_a_rs1", 64'(ia.IDEX_d_rs1), 64'd0);
      chk("x0w_b_rs1", ib.IDEX_d_rs1, 64'd0);
      wb_en = 1'b0;
      tick();
      chk("x0w_a_rs1_after", 64'(ia.IDEX_d_rs1), 64'd0);

      // load-use: lw x1,0(x2) then add x3,x1,x4
      issue(32'h0001_2083, 64'h200);
      #1 chk("lu_nostall_before", 64'(ia.ID_c_stall), 64'd0);
      tick();
      chk("lu_lw_inst", 64'(ia.IDEX_d_inst), 64'h0001_2083);
      issue(32'h0040_81B3, 64'h204);
      #1;
      chk("lu_a_stall", 64'(ia.ID_c_stall), 64'd1);
      chk("lu_b_stall", 64'(ib.ID_c_stall), 64'd1);
      tick();
      chk_bubble("lu_bubble");
      chk("lu_stall_one_cycle", 64'(ia.ID_c_stall), 64'd0);
      tick();
      chk("lu_add_inst",  64'(ia.IDEX_d_inst), 64'h0040_81B3);
      chk("lu_add_valid", 64'(ia.IDEX_valid), 64'd1);
      chk("lu_add_pc",    64'(ib.IDEX_d_pc), 64'h204);

      // lui has no source register, so a load to x1 ahead of it is harmless
      issue(32'h0001_2083, 64'h208);
      tick();
      issue(32'h0000_10B7, 64'h20C);
      #1 chk("lui_nostall", 64'(ia.ID_c_stall), 64'd0);
      tick();
      chk("lui_inst", 64'(ia.IDEX_d_inst), 64'h0000_10B7);
      chk("lui_imm",  64'(ia.IDEX_d_imm), 64'h1000);

      imm_inst[0] = 32'hFE00_0EE3; imm_ea[0] = 64'hFFFF_FFFC; imm_eb[0] = 64'hFFFF_FFFF_FFFF_FFFC;
      imm_inst[1] = 32'h0010_00EF; imm_ea[1] = 64'h800;       imm_eb[1] = 64'h800;
      imm_inst[2] = 32'h8000_00B7; imm_ea[2] = 64'h8000_0000; imm_eb[2] = 64'hFFFF_FFFF_8000_0000;
      imm_inst[3] = 32'hFE11_2C23; imm_ea[3] = 64'hFFFF_FFF8; imm_eb[3] = 64'hFFFF_FFFF_FFFF_FFF8;
      imm_inst[4] = 32'hFFF0_0093; imm_ea[4] = 64'hFFFF_FFFF; imm_eb[4] = 64'hFFFF_FFFF_FFFF_FFFF;
      imm_inst[5] = 32'hFFF0_8033; imm_ea[5] = 64'd0;         imm_eb[5] = 64'd0;
      for (int i = 0; i < 6; i++) begin
         issue(imm_inst[i], 64'h300);
         tick();
         chk($sformatf("imm%0d_a", i), 64'(ia.IDEX_d_imm), imm_ea[i]);
         chk($sformatf("imm%0d_b", i), ib.IDEX_d_imm, imm_eb[i]);
      end

      // flush while the load-use condition holds, with an x0 write in flight
      issue(32'h0001_2083, 64'h400);
      tick();
      issue(32'h0040_81B3, 64'h404);
      flush = 1'b1; wb_en = 1'b1; wb_ix = 5'd0; wb_rd = 64'h55;
      #1;
      chk("fl_a_stall", 64'(ia.ID_c_stall), 64'd0);
      chk("fl_b_stall", 64'(ib.ID_c_stall), 64'd0);
      tick();
      chk_bubble("fl_bubble");
      flush = 1'b0; wb_en = 1'b0;
      issue(32'h0000_0093, 64'h408);
      tick();
      chk("fl_x0_a", 64'(ia.IDEX_d_rs1), 64'd0);
      chk("fl_x0_b", ib.IDEX_d_rs1, 64'd0);

      // mid-operation reset clears a pending stall and the register file
      valid = 1'b0; wb_en = 1'b1; wb_ix = 5'd10; wb_rd = 64'hABC;
      tick();
      wb_en = 1'b0;
      issue(32'h0005_0093, 64'h500);
      tick();
      chk("mr_x10_before", 64'(ia.IDEX_d_rs1), 64'hABC);
      issue(32'h0001_2083, 64'h504);
      tick();
      issue(32'h0040_81B3, 64'h508);
      #1 chk("mr_stall_pending", 64'(ia.ID_c_stall), 64'd1);
      rst = 1'b1;
      #1;
      chk("mr_a_stall", 64'(ia.ID_c_stall), 64'd0);
      chk("mr_b_stall", 64'(ib.ID_c_stall), 64'd0);
      chk_bubble("mr");
      @(posedge clk);
      #1 rst = 1'b0;
      issue(32'h0005_0093, 64'h50C);
      tick();
      chk("mr_x10_a_cleared", 64'(ia.IDEX_d_rs1), 64'd0);
      chk("mr_x10_b_cleared", ib.IDEX_d_rs1, 64'd0);
      chk("mr_first_capture", 64'(ia.IDEX_valid), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
